// File: rtl/maze_walker_param.sv
`default_nettype none
// maze_walker_param: loads an NxN bit-serial maze, then walks (0,0)->(N-1,N-1) with a
// right- or left-hand wall-following rule, one registered move per cycle, under a step budget.
module maze_walker_param #(
  parameter int N         = 17,
  parameter int MAX_STEPS = 1024,
  parameter int SW        = $clog2(MAX_STEPS + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in,
  input  logic       hand,
  output logic       out_valid,
  output logic [1:0] out,
  output logic       out_fail
);

  localparam int NN  = N * N;
  localparam int IW1 = $clog2(NN) + 1;
  localparam int CW  = $clog2(N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_WALK = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [IW1-1:0] NN_L   = IW1'(NN);
  localparam logic [IW1-1:0] N_L    = IW1'(N);
  localparam logic [CW-1:0]  LAST   = CW'(N - 1);
  localparam logic [SW-1:0]  BUDGET = SW'(MAX_STEPS);

  // Relative turn offsets in try order, entry k at bits [2k+1:2k].
  localparam logic [7:0] RH_ORDER = 8'b10_11_00_01;
  localparam logic [7:0] LH_ORDER = 8'b10_01_00_11;

  logic [1:0]     state_q, state_d;
  logic [NN-1:0]  map_q, map_d;
  logic [IW1-1:0] idx_q, idx_d;
  logic           hand_q, hand_d;
  logic [CW-1:0]  r_q, r_d, c_q, c_d;
  logic [1:0]     dir_q, dir_d;
  logic [SW-1:0]  steps_q, steps_d;
  logic           out_valid_q, out_valid_d;
  logic [1:0]     out_q, out_d;
  logic           out_fail_q, out_fail_d;

  logic [IW1-1:0] cur_idx;
  logic [3:0]     open_dir;
  logic           found;
  logic [1:0]     pick;
  logic [1:0]     cand;
  logic [1:0]     off;
  logic [CW-1:0]  nr, nc;
  logic           goal_next;
  logic           walk_fail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      map_q       <= '0;
      idx_q       <= '0;
      hand_q      <= 1'b0;
      r_q         <= '0;
      c_q         <= '0;
      dir_q       <= 2'd0;
      steps_q     <= '0;
      out_valid_q <= 1'b0;
      out_q       <= 2'd0;
      out_fail_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      map_q       <= map_d;
      idx_q       <= idx_d;
      hand_q      <= hand_d;
      r_q         <= r_d;
      c_q         <= c_d;
      dir_q       <= dir_d;
      steps_q     <= steps_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_fail_q  <= out_fail_d;
    end
  end

  // Neighbour openness by absolute direction; off-grid neighbours are walls.
  always_comb begin
    cur_idx     = IW1'(r_q) * N_L + IW1'(c_q);
    open_dir[0] = (c_q != LAST)  && |(map_q & (NN'(1) << (cur_idx + IW1'(1))));
    open_dir[1] = (r_q != LAST)  && |(map_q & (NN'(1) << (cur_idx + N_L)));
    open_dir[2] = (c_q != '0)    && |(map_q & (NN'(1) << (cur_idx - IW1'(1))));
    open_dir[3] = (r_q != '0)    && |(map_q & (NN'(1) << (cur_idx - N_L)));
  end

  always_comb begin
    found = 1'b0;
    pick  = dir_q;
    cand  = dir_q;
    off   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      off  = hand_q ? LH_ORDER[2*k +: 2] : RH_ORDER[2*k +: 2];
      cand = dir_q + off;
      if (!found && open_dir[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    nr = r_q;
    nc = c_q;
    case (pick)
      2'd0:    nc = c_q + CW'(1);
      2'd1:    nr = r_q + CW'(1);
      2'd2:    nc = c_q - CW'(1);
      default: nr = r_q - CW'(1);
    endcase
    goal_next = (nr == LAST) && (nc == LAST);
    // A dead-ended start (wall, or no open neighbour) fails exactly like a walled start.
    walk_fail = !map_q[0] || (steps_q == BUDGET) || !found;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_LOAD;
      S_LOAD:  if (!in_valid) state_d = S_WALK;
      S_WALK:  if (walk_fail || goal_next) state_d = S_FIN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    map_d       = map_q;
    idx_d       = idx_q;
    hand_d      = hand_q;
    r_d         = r_q;
    c_d         = c_q;
    dir_d       = dir_q;
    steps_d     = steps_q;
    out_valid_d = 1'b0;
    out_d       = 2'd0;
    out_fail_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        map_d   = '0;
        idx_d   = '0;
        r_d     = '0;
        c_d     = '0;
        dir_d   = 2'd0;
        steps_d = '0;
        if (in_valid) begin
          map_d  = NN'(in);
          idx_d  = IW1'(1);
          hand_d = hand;
        end
      end
      S_LOAD: begin
        if (in_valid && (idx_q != NN_L)) begin
          map_d = map_q | (NN'(in) << idx_q);
          idx_d = idx_q + IW1'(1);
        end
      end
      S_WALK: begin
        if (walk_fail) begin
          out_fail_d = 1'b1;
        end else begin
          r_d         = nr;
          c_d         = nc;
          dir_d       = pick;
          steps_d     = steps_q + SW'(1);
          out_valid_d = 1'b1;
          out_d       = pick;
        end
      end
      default: ;
    endcase
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_fail  = out_fail_q;

endmodule
`default_nettype wire

// File: tb/tb_maze_walker_param.sv
`default_nettype none
// tb_maze_walker_param: drives N=4 (budget 20) and N=17 (default) walkers against a
// behavioural wall-follower model, checking every output cycle of every walk.
module tb_maze_walker_param;

  logic       clk;
  logic       rst_n;
  logic       iv4, b4, h4, ov4, of4;
  logic [1:0] o4;
  logic       iv17, b17, h17, ov17, of17;
  logic [1:0] o17;

  int n_checks;
  int n_errors;

  bit mz [0:288];
  int exp_moves[$];
  bit exp_fail;
  int run_id;

  maze_walker_param #(.N(4), .MAX_STEPS(20)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in(b4), .hand(h4),
    .out_valid(ov4), .out(o4), .out_fail(of4)
  );

  maze_walker_param dut17 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv17), .in(b17), .hand(h17),
    .out_valid(ov17), .out(o17), .out_fail(of17)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got valid/fail/move=%b required %b", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] obs(input int sel);
    return (sel == 0) ? {ov4, of4, o4} : {ov17, of17, o17};
  endfunction

  task automatic drive(input int sel, input bit v, input bit b, input bit h);
    if (sel == 0) begin iv4 = v; b4 = b; h4 = h; end
    else begin iv17 = v; b17 = b; h17 = h; end
  endtask

  function automatic bit cell_open(input int n, input int nbits, input int r, input int c);
    if (r < 0 || c < 0 || r >= n || c >= n) return 1'b0;
    if (r * n + c >= nbits) return 1'b0;
    return mz[r * n + c];
  endfunction

  // Reference walker: plain coordinates and headings, tries turns in rule order.
  task automatic model(input int n, input int maxs, input bit hnd, input int nbits);
    int r, c, hd, d, chosen, nr2, nc2;
    int pref[4];
    int dr[4];
    int dc[4];
    dr = '{0, 1, 0, -1};
    dc = '{1, 0, -1, 0};
    if (hnd) pref = '{3, 0, 1, 2};
    else     pref = '{1, 0, 3, 2};
    exp_moves.delete();
    exp_fail = 1'b0;
    r = 0; c = 0; hd = 0;
    if (!cell_open(n, nbits, 0, 0)) begin exp_fail = 1'b1; return; end
    while (1) begin
      if (exp_moves.size() == maxs) begin exp_fail = 1'b1; return; end
      chosen = -1;
      for (int j = 0; j < 4; j++) begin
        d = (hd + pref[j]) % 4;
        if (chosen < 0 && cell_open(n, nbits, r + dr[d], c + dc[d])) chosen = d;
      end
      if (chosen < 0) begin exp_fail = 1'b1; return; end
      nr2 = r + dr[chosen];
      nc2 = c + dc[chosen];
      r = nr2; c = nc2; hd = chosen;
      exp_moves.push_back(chosen);
      if (r == n - 1 && c == n - 1) return;
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge with it back in IDLE.
  task automatic run_maze(input int sel, input bit hnd, input int nbits, input int abort_at);
    int n, maxs, len, kmax;
    logic [3:0] e;
    n    = (sel == 0) ? 4 : 17;
    maxs = (sel == 0) ? 20 : 1024;
    run_id++;
    model(n, maxs, hnd, nbits);
    len  = exp_moves.size();
    kmax = exp_fail ? len + 2 : len + 1;
    for (int i = 0; i < nbits; i++) begin
      drive(sel, 1'b1, mz[i], (i == 0) ? hnd : 1'($urandom));
      @(negedge clk);
    end
    drive(sel, 1'b0, 1'($urandom), 1'($urandom));
    for (int k = 0; k <= kmax; k++) begin
      @(negedge clk);
      if (k >= 1 && k <= len)            e = {2'b10, 2'(exp_moves[k-1])};
      else if (exp_fail && k == len + 1) e = 4'b0100;
      else                               e = 4'b0000;
      chk($sformatf("run%0d cyc%0d", run_id, k), obs(sel), e);
      if (k == abort_at) begin
        #2 rst_n = 1'b0;
        #1 chk($sformatf("run%0d async_rst", run_id), obs(sel), 4'b0000);
        drive(sel, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      drive(sel, (k < kmax) ? 1'($urandom) : 1'b0, 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic fill(input int cells, input bit v);
    for (int i = 0; i < 289; i++) mz[i] = (i < cells) ? v : 1'b0;
  endtask

  task automatic fill_random(input int cells, input int pct);
    for (int i = 0; i < 289; i++) mz[i] = (i < cells) && ($urandom_range(0, 99) < pct);
    mz[0] = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    run_id   = 0;
    rst_n    = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("reset4", obs(0), 4'b0000);
    chk("reset17", obs(1), 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);

    fill(16, 1'b1);
    run_maze(0, 1'b0, 16, -1);
    run_maze(0, 1'b1, 16, -1);
    run_maze(0, 1'b0, 20, -1);

    fill(16, 1'b1);
    for (int i = 0; i < 16; i++) mz[i] = (i / 4 < 3) && (i % 4 < 3);
    run_maze(0, 1'b0, 16, -1);

    fill(16, 1'b1);
    mz[0] = 1'b0;
    run_maze(0, 1'($urandom), 16, -1);

    fill(16, 1'b1);
    run_maze(0, 1'b0, 8, -1);

    fill(16, 1'b1);
    mz[1] = 1'b0;
    mz[4] = 1'b0;
    run_maze(0, 1'b1, 16, -1);

    // Serpentine: even rows open, odd rows open only at alternating ends.
    for (int i = 0; i < 289; i++) begin
      int r, c;
      r = i / 17;
      c = i % 17;
      mz[i] = (r % 2 == 0) || (r % 4 == 1 && c == 16) || (r % 4 == 3 && c == 0);
    end
    run_maze(1, 1'b0, 289, 5);
    run_maze(1, 1'b0, 289, -1);
    run_maze(1, 1'b1, 289, -1);

    for (int t = 0; t < 8; t++) begin
      fill_random(16, 70);
      run_maze(0, 1'($urandom), (t % 3 == 0) ? $urandom_range(1, 16) : 16, -1);
    end
    for (int t = 0; t < 4; t++) begin
      fill_random(289, 72);
      run_maze(1, 1'($urandom), 289, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/maze_walker_param.md
# maze_walker_param

Parametrised wall-following maze solver for the MAZE lab family. It loads an N×N bit-serial maze and walks from the top-left cell to the bottom-right cell using a selectable right-hand or left-hand rule. It streams one move per cycle and aborts with a fail pulse if a step budget runs out. It sits between the serial pattern source and the move checker, with the same in/out handshake style as the fixed 17×17 solver.

## Interface
Parameters:
- N, 17, interior maze side in cells (N ≥ 2); cells outside 0..N-1 are implicit walls
- MAX_STEPS, 1024, move budget per maze; exceeding it aborts the walk
- SW, $clog2(MAX_STEPS+1), step counter width (derived, not overridden)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- in_valid  in  1  high for each maze bit, consecutive cycles
- in  in  1  maze bit, row-major, index r*N+c; 1 = path, 0 = wall
- hand  in  1  0 = right-hand rule, 1 = left-hand rule; sampled on the first in_valid cycle of a maze
- out_valid  out  1  high while out carries a move
- out  out  2  move: 0 right (c+1), 1 down (r+1), 2 left (c-1), 3 up (r-1)
- out_fail  out  1  one-cycle pulse: walk aborted (start is a wall, or budget exhausted)

## Operation
- States: IDLE, LOAD, WALK, FIN.
- IDLE: map cleared to all walls, position (0,0), heading right (0), step counter 0. in_valid=1 → LOAD, storing bit 0 and latching hand.
- LOAD: each in_valid cycle stores the next bit. Bits beyond N*N are ignored. If in_valid drops early, the missing cells stay walls. First cycle with in_valid=0 → WALK.
- WALK, per cycle:
  - Right-hand rule tries, in order: turn right (heading+1 mod 4), straight, turn left (heading+3), back (heading+2).
  - Left-hand rule tries: turn left, straight, turn right, back.
  - The first open neighbour wins. Position and heading update, out = the new heading, out_valid=1, and the step counter increments.
  - If the cell entered is (N-1,N-1), → FIN.
  - If the start cell (0,0) is a wall, emit no moves: pulse out_fail, → FIN.
  - If the counter equals MAX_STEPS and the goal has not been reached, the move is not emitted: pulse out_fail, → FIN.
  - A fully enclosed start cell bounces in place ("back" into a wall is never chosen; if all four neighbours are walls, treat it as start-wall fail).
- FIN: out_valid=0, out=0, out_fail=0. → IDLE next cycle. The map clears in IDLE.
- in_valid during WALK or FIN is ignored. A new maze is accepted only from IDLE.
- Step counter saturates and never wraps.

## Timing
- Reset values: out_valid=0, out=0, out_fail=0, state IDLE, map all walls. An asserted rst_n mid-LOAD or mid-WALK forces these immediately (asynchronous). Walking resumes only after a fresh load.
- Let T be the first rising edge at which in_valid is sampled 0 after a load.
  - First move is registered at edge T+1.
  - Move k (1-based) is visible after edge T+k.
- out_valid stays continuously high for exactly the path length L, then 0 after edge T+L+1.
- Fail cases:
  - Start wall: out_fail is high after edge T+1 for one cycle, with no out_valid.
  - Budget: out_valid is high for MAX_STEPS cycles, then out_fail is high for one cycle in place of move MAX_STEPS+1.
- out_valid and out_fail are never high in the same cycle.
- Minimum gap from end of output to the next accepted in_valid: 2 cycles (FIN, IDLE).

## Test plan
- N=4, all 16 bits 1, hand=0 → out sequence 1,1,1,0,0,0, out_valid high 6 cycles starting edge T+1, out_fail never high.
- N=4, all bits 1, hand=1 → out sequence 0,0,0,1,1,1, then out_valid low; rerun back-to-back to check the map is cleared.
- N=4, MAX_STEPS=20, row 3 and column 3 all 0, rest 1, hand=0 → exactly 20 out_valid cycles circling the 3×3 block, then a single out_fail pulse, then IDLE.
- N=4, bit 0 = 0 → no out_valid, out_fail high for one cycle after edge T+1.
- N=4, in_valid dropped after 8 bits (all 1) → rows 2–3 are walls, goal unreachable, budget fail pulse after MAX_STEPS moves.
- N=17 default, rst_n pulsed low at move 5 of a serpentine maze → all outputs 0 the same cycle; a reloaded maze produces its full correct sequence from move 1.
